// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch front end. Issues word-aligned requests to an instruction
// memory and buffers the returned words together with their addresses in a
// two-entry FIFO. The number of buffered entries plus outstanding requests
// never exceeds two, and at most one request is outstanding at a time.
//
// A redirect flushes the FIFO and restarts fetch at a new address. A request
// that is still outstanding when a redirect arrives cannot be withdrawn. The
// unit therefore keeps requesting the old address until that request is
// acknowledged, throws the returned word away, and then fetches from the
// newest redirect target.
//
// Parameters
//   RESET_PC     address of the first instruction fetched after reset
//
// Ports
//   CLK          sole clock, rising edge
//   RST          synchronous, active-high reset
//   imem_req     memory request, held high until acknowledged
//   imem_addr    word-aligned fetch address, valid while imem_req=1
//   imem_ack     memory completion, only looked at while imem_req=1
//   imem_rdata   instruction word, valid with imem_ack
//   redirect     taken branch/jump: flush and restart fetch
//   redirect_pc  restart address; bits [1:0] are forced to zero
//   instr_valid  FIFO head holds an instruction
//   instr        head instruction word
//   instr_pc     address of the head instruction
//   instr_ready  consumer takes the head when instr_valid && instr_ready
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
);

    // IDLE   : no request outstanding; a request may start this cycle
    // BUSY   : request outstanding, its data will be kept
    // SQUASH : request outstanding, its data will be discarded
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY   = 2'd1,
        ST_SQUASH = 2'd2
    } state_e;

    typedef struct packed {
        logic [31:0] word;
        logic [31:0] pc;
    } entry_t;

    // Control state
    state_e      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;   // next address to fetch
    logic [31:0] req_addr_q, req_addr_d;   // address of the outstanding request
    logic [1:0]  count_q, count_d;         // FIFO occupancy, 0..2

    // FIFO storage: head is what the consumer sees, tail is the second entry
    entry_t      head_q, head_d;
    entry_t      tail_q, tail_d;

    // Combinational helpers
    logic        req_raw;
    logic [31:0] addr_raw;
    logic        ack_fire;
    logic        enq;
    logic        deq;
    logic [1:0]  count_mid;
    logic [31:0] redirect_target;
    logic [31:0] next_seq_pc;
    entry_t      new_entry;

    // -------------------------------------------------------------------------
    // Request generation
    // -------------------------------------------------------------------------
    // In IDLE the request is raised in the same cycle a credit is free. A
    // redirect in that cycle holds the request back, so the next request goes
    // straight to the new target instead of being issued and then squashed.
    always_comb begin
        // NOTE: every signal written in an always_comb gets a default first, so
        // no path through the case leaves it unassigned and no latch is inferred.
        req_raw  = 1'b0;
        addr_raw = fetch_pc_q;
        case (state_q)
            ST_IDLE: begin
                if ((count_q < 2'd2) && !redirect) begin
                    req_raw  = 1'b1;
                    addr_raw = fetch_pc_q;
                end
            end
            ST_BUSY, ST_SQUASH: begin
                req_raw  = 1'b1;
                addr_raw = req_addr_q;
            end
            default: begin
                req_raw  = 1'b0;
                addr_raw = fetch_pc_q;
            end
        endcase
    end

    // Reset forces the request low at once. This also covers the case where
    // reset arrives while a request is still outstanding.
    assign imem_req  = req_raw && !RST;
    assign imem_addr = addr_raw;

    // An acknowledge only counts while a request is visible on the port.
    assign ack_fire = imem_req && imem_ack;

    // Keep the word unless it belongs to a squashed request or a redirect
    // arrives in the same cycle.
    assign enq = ack_fire && !redirect && (state_q != ST_SQUASH);
    assign deq = instr_valid && instr_ready;

    // Masking keeps every bit of redirect_pc in use. The low two bits are
    // simply cleared.
    assign redirect_target = redirect_pc & ~32'd3;

    // Address arithmetic wraps at 2^32.
    assign next_seq_pc = addr_raw + 32'd4;

    assign new_entry = '{word: imem_rdata, pc: addr_raw};

    // -------------------------------------------------------------------------
    // FIFO next-state
    // -------------------------------------------------------------------------
    // The dequeue is applied first, then the enqueue lands in the first free
    // slot. A dequeue and an enqueue in the same cycle therefore leave the
    // occupancy unchanged. A redirect empties the FIFO whatever else happens.
    always_comb begin
        head_d    = head_q;
        tail_d    = tail_q;
        count_mid = count_q - {1'b0, deq};

        if (deq) begin
            head_d = tail_q;
        end

        if (enq) begin
            if (count_mid == 2'd0) begin
                head_d = new_entry;
            end else begin
                tail_d = new_entry;
            end
        end

        count_d = count_mid + {1'b0, enq};

        if (redirect) begin
            count_d = 2'd0;
        end
    end

    // -------------------------------------------------------------------------
    // FSM next-state and fetch address
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_addr_d = req_addr_q;

        case (state_q)
            ST_IDLE: begin
                // The request was raised but not acknowledged, so it stays
                // outstanding at the current fetch address.
                if (imem_req && !ack_fire) begin
                    state_d    = ST_BUSY;
                    req_addr_d = fetch_pc_q;
                end
            end
            ST_BUSY: begin
                if (ack_fire) begin
                    state_d = ST_IDLE;
                end else if (redirect) begin
                    state_d = ST_SQUASH;
                end
            end
            ST_SQUASH: begin
                if (ack_fire) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A kept word advances the sequential address. Issue continues
        // back-to-back only while the buffer still has room after this cycle.
        if (enq) begin
            fetch_pc_d = next_seq_pc;
            req_addr_d = next_seq_pc;
            state_d    = (count_d < 2'd2) ? ST_BUSY : ST_IDLE;
        end

        // The newest redirect target always wins, including during SQUASH.
        if (redirect) begin
            fetch_pc_d = redirect_target;
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // flop samples the values from before the edge.
        if (RST) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= RESET_PC;
            req_addr_q <= RESET_PC;
            count_q    <= 2'd0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_addr_q <= req_addr_d;
            count_q    <= count_d;
        end
    end

    // NOTE: FIFO payload registers have no reset. count_q alone decides
    // whether they hold anything meaningful, so resetting them would only add
    // load to the reset net.
    always_ff @(posedge CLK) begin
        head_q <= head_d;
        tail_q <= tail_d;
    end

    // -------------------------------------------------------------------------
    // Consumer side
    // -------------------------------------------------------------------------
    assign instr_valid = !RST && (count_q != 2'd0);
    assign instr       = head_q.word;
    assign instr_pc    = head_q.pc;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the address of the first instruction fetched after reset.
REQ-002 CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 RST  input  1  synchronous, active-high reset.
REQ-004 imem_req  output  1  instruction-memory request; held high until acknowledged.
REQ-005 imem_addr  output  32  word-aligned fetch address; valid while imem_req=1.
REQ-006 imem_ack  input  1  memory completion, sampled only while imem_req=1; may be high in the same cycle imem_req rises.
REQ-007 imem_rdata  input  32  instruction word, valid when imem_ack=1.
REQ-008 redirect  input  1  branch/jump taken; flush and restart fetch.
REQ-009 redirect_pc  input  32  new fetch address; bits [1:0] ignored and treated as 0.
REQ-010 instr_valid  output  1  buffer head holds a valid instruction.
REQ-011 instr  output  32  head instruction word.
REQ-012 instr_pc  output  32  address of the head instruction.
REQ-013 instr_ready  input  1  consumer accepts head when instr_valid=1 and instr_ready=1.

Function
REQ-014 Two-entry FIFO of {instr, pc}; instr_valid = not empty; instr/instr_pc driven from head register.
REQ-015 Credit rule: occupancy + outstanding requests <= 2; at most one request outstanding at any time.
REQ-016 FSM states: IDLE (no request), BUSY (request outstanding), SQUASH (outstanding request to be discarded).
REQ-017 IDLE -> BUSY when a credit is free and redirect=0; imem_req asserted combinationally in that cycle with imem_addr=fetch_pc.
REQ-018 BUSY: imem_req=1, imem_addr held stable until imem_ack; on ack, {imem_rdata, imem_addr} enqueued, fetch_pc <= imem_addr+4, state -> BUSY if a credit remains, else IDLE.
REQ-019 Address arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
REQ-020 Zero-wait memory (ack in request cycle) with instr_ready=1 sustains one instruction per cycle; enqueue-to-instr_valid latency is one cycle.
REQ-021 Dequeue and enqueue in the same cycle are both honoured; occupancy unchanged.
REQ-022 redirect=1: FIFO flushed at the edge (instr_valid=0 next cycle), fetch_pc <= {redirect_pc[31:2],2'b00}; a simultaneous dequeue is discarded, redirect wins.
REQ-023 redirect in BUSY with imem_ack=0: state -> SQUASH; imem_req stays high with old imem_addr until ack; returned data discarded; then fetch resumes from the redirect target.
REQ-024 redirect in the same cycle as imem_ack: acknowledged data discarded, no SQUASH; next request uses the redirect target.
REQ-025 redirect during SQUASH: fetch_pc updated to the newest target; remains in SQUASH until the old ack.
REQ-026 imem_ack while imem_req=0 is ignored.

Reset
REQ-027 While RST=1: imem_req=0, instr_valid=0, FIFO empty, state IDLE, fetch_pc <= RESET_PC; redirect and imem_ack ignored.
REQ-028 First request issues in the first cycle with RST=0, imem_addr=RESET_PC.
REQ-029 RST asserted mid-request abandons the outstanding request; a late imem_ack after reset is not enqueued unless imem_req is high.

Verification
REQ-030 Reset, zero-wait memory, instr_ready=1 -> instr_pc 0x0,0x4,0x8,... one per cycle, instr matching memory.
REQ-031 instr_ready=0 for 6 cycles, memory ack latency 1 -> exactly two entries buffered, imem_req low, addresses 0x0/0x4 retained; release -> 0x8 fetched next.
REQ-032 Memory latency 3, redirect to 0x103 in second cycle of BUSY -> old ack discarded, next imem_addr=0x100, first delivered instr_pc=0x100.
REQ-033 redirect to 0x40 coincident with imem_ack and dequeue -> instr_valid=0 next cycle, next imem_addr=0x40.
REQ-034 Redirect to 0xFFFF_FFF8, zero-wait -> instr_pc 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
REQ-035 RST pulsed while BUSY with ack pending -> instr_valid=0, imem_req=0 during reset, restart at RESET_PC.
